// File: rtl/target_gen_lfsr_if.sv
// Target handshake between the LFSR target generator (master) and its consumer (slave).
interface target_gen_lfsr_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
) ();
  logic           req;
  logic           target_ack;
  logic           target_valid;
  logic [X_W-1:0] target_x;
  logic [Y_W-1:0] target_y;
  logic           fallback;

  modport master (
    input  req,
    input  target_ack,
    output target_valid,
    output target_x,
    output target_y,
    output fallback
  );

  modport slave (
    output req,
    output target_ack,
    input  target_valid,
    input  target_x,
    input  target_y,
    input  fallback
  );
endinterface

// File: rtl/target_gen_lfsr.sv
// Pseudo-random playfield target generator: free-running Galois LFSR, bounded
// rejection sampling of X/Y candidates, clamped fallback, valid/ack presentation.
module target_gen_lfsr #(
  parameter int unsigned          LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]    TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0]    RESET_SEED = 16'hACE1,
  parameter int unsigned          X_W        = 8,
  parameter int unsigned          Y_W        = 7,
  parameter int unsigned          X_MAX      = 159,
  parameter int unsigned          Y_MAX      = 119,
  parameter int unsigned          MAX_TRIES  = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  target_gen_lfsr_if.master tgt,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int unsigned TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StSearch, StValid} state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               fb_q, fb_d;

  logic [X_W-1:0] cx, clamp_x;
  logic [Y_W-1:0] cy, clamp_y;
  logic           accept;

  // Seed zero would lock the LFSR, so it is mapped to 1.
  always_comb begin
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end else begin
      lfsr_d = lfsr_q >> 1;
    end
  end

  // For an accepted draw the clamp is the identity, so one latch path serves both cases.
  always_comb begin
    cx      = lfsr_q[X_W-1:0];
    cy      = lfsr_q[X_W+Y_W-1:X_W];
    accept  = (cx <= X_LIM) && (cy <= Y_LIM);
    clamp_x = (cx > X_LIM) ? X_LIM : cx;
    clamp_y = (cy > Y_LIM) ? Y_LIM : cy;
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    x_d     = x_q;
    y_d     = y_q;
    fb_d    = fb_q;
    unique case (state_q)
      StIdle: begin
        if (tgt.req) begin
          if (accept || (MAX_TRIES == 1)) begin
            x_d     = clamp_x;
            y_d     = clamp_y;
            fb_d    = ~accept;
            tries_d = '0;
            state_d = StValid;
          end else begin
            tries_d = TRIES_W'(1);
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (accept || (tries_q == LAST_TRY)) begin
          x_d     = clamp_x;
          y_d     = clamp_y;
          fb_d    = ~accept;
          tries_d = '0;
          state_d = StValid;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
        end
      end
      StValid: begin
        if (tgt.target_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        tries_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      lfsr_q  <= RESET_SEED;
      tries_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fb_q    <= fb_d;
    end
  end

  assign tgt.target_valid = (state_q == StValid);
  assign tgt.target_x     = x_q;
  assign tgt.target_y     = y_q;
  assign tgt.fallback     = fb_q;
  assign busy             = (state_q == StSearch);
  assign lfsr_state       = lfsr_q;

endmodule
